// File: rtl/data_bram_arbiter_if.sv
// rtl/data_bram_arbiter_if.sv - Request/response and BRAM signal bundle for data_bram_arbiter
//
// Purpose: groups the four request ports (fill, store, load, evict), the two
// read-response channels and the BRAM-side signals into one bundle.
// Ports (signals):
//   fill_valid/fill_ready, fill_addr, fill_data          full-line refill write
//   st_valid/st_ready, st_addr, st_data, st_byteena      CPU store
//   ld_valid/ld_ready, ld_addr, ld_rvalid, ld_rdata      CPU load + response
//   ev_valid/ev_ready, ev_addr, ev_rvalid, ev_rdata      eviction read + response
//   bram_aclr, bram_wren, bram_wraddress, bram_data,
//   bram_byteena, bram_rden, bram_rdaddress, bram_q      BRAM side
// Modports: slave = arbiter side, master = requesters plus BRAM.
interface data_bram_arbiter_if #(
    parameter int DATA_WIDTH          = 256,
    parameter int ADDR_WIDTH          = 8,
    parameter int NUM_BYTES_PER_ENTRY = DATA_WIDTH / 8
);
    logic                           fill_valid;
    logic                           fill_ready;
    logic [ADDR_WIDTH-1:0]          fill_addr;
    logic [DATA_WIDTH-1:0]          fill_data;

    logic                           st_valid;
    logic                           st_ready;
    logic [ADDR_WIDTH-1:0]          st_addr;
    logic [DATA_WIDTH-1:0]          st_data;
    logic [NUM_BYTES_PER_ENTRY-1:0] st_byteena;

    logic                           ld_valid;
    logic                           ld_ready;
    logic [ADDR_WIDTH-1:0]          ld_addr;
    logic                           ld_rvalid;
    logic [DATA_WIDTH-1:0]          ld_rdata;

    logic                           ev_valid;
    logic                           ev_ready;
    logic [ADDR_WIDTH-1:0]          ev_addr;
    logic                           ev_rvalid;
    logic [DATA_WIDTH-1:0]          ev_rdata;

    logic                           bram_aclr;
    logic                           bram_wren;
    logic [ADDR_WIDTH-1:0]          bram_wraddress;
    logic [DATA_WIDTH-1:0]          bram_data;
    logic [NUM_BYTES_PER_ENTRY-1:0] bram_byteena;
    logic                           bram_rden;
    logic [ADDR_WIDTH-1:0]          bram_rdaddress;
    logic [DATA_WIDTH-1:0]          bram_q;

    modport slave (
        input  fill_valid, fill_addr, fill_data,
        output fill_ready,
        input  st_valid, st_addr, st_data, st_byteena,
        output st_ready,
        input  ld_valid, ld_addr,
        output ld_ready, ld_rvalid, ld_rdata,
        input  ev_valid, ev_addr,
        output ev_ready, ev_rvalid, ev_rdata,
        output bram_aclr, bram_wren, bram_wraddress, bram_data, bram_byteena,
        output bram_rden, bram_rdaddress,
        input  bram_q
    );

    modport master (
        output fill_valid, fill_addr, fill_data,
        input  fill_ready,
        output st_valid, st_addr, st_data, st_byteena,
        input  st_ready,
        output ld_valid, ld_addr,
        input  ld_ready, ld_rvalid, ld_rdata,
        output ev_valid, ev_addr,
        input  ev_ready, ev_rvalid, ev_rdata,
        input  bram_aclr, bram_wren, bram_wraddress, bram_data, bram_byteena,
        input  bram_rden, bram_rdaddress,
        output bram_q
    );
endinterface

// File: rtl/data_bram_arbiter.sv
// rtl/data_bram_arbiter.sv - Two-port data BRAM arbiter with store anti-starvation and load forwarding
//
// Purpose: arbitrates one write per cycle (fill over store, with a starvation
// limit for stores) and one read per cycle (evict over load) onto a simple
// dual-port BRAM with 1-cycle registered read. A load that collides with a
// same-cycle write to the same line sees the written bytes merged in.
// Ports:
//   clock   in  rising-edge clock
//   aclr_n  in  asynchronous active-low reset
//   bus     slave modport of data_bram_arbiter_if (requests, responses, BRAM)
module data_bram_arbiter #(
    parameter int DATA_WIDTH          = 256,
    parameter int ADDR_WIDTH          = 8,
    parameter int NUM_BYTES_PER_ENTRY = DATA_WIDTH / 8,
    parameter int STARVE_MAX          = 4
) (
    input  logic               clock,
    input  logic               aclr_n,
    data_bram_arbiter_if.slave bus
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    logic [SW-1:0]                  r_starve_cnt;
    logic                           r_rd_pending;
    logic                           r_rd_tag;      // 1: evict response, 0: load response
    logic                           r_fwd_en;
    logic [DATA_WIDTH-1:0]          r_fwd_data;
    logic [NUM_BYTES_PER_ENTRY-1:0] r_fwd_be;

    logic                           w_store_prio;
    logic                           w_fill_grant;
    logic                           w_st_grant;
    logic                           w_wr_grant;
    logic                           w_ld_grant;
    logic                           w_ev_grant;
    logic                           w_rd_grant;
    logic [ADDR_WIDTH-1:0]          w_wr_addr;
    logic [DATA_WIDTH-1:0]          w_wr_data;
    logic [NUM_BYTES_PER_ENTRY-1:0] w_wr_be;
    logic [DATA_WIDTH-1:0]          w_ld_merged;

    // Readies depend only on valids and the starve counter. They are gated
    // by aclr_n so every ready drops the moment reset asserts.
    assign w_store_prio  = bus.st_valid && (r_starve_cnt == STARVE_LIMIT);
    assign bus.fill_ready = aclr_n && !w_store_prio;
    assign bus.st_ready   = aclr_n && (!bus.fill_valid || w_store_prio);
    assign bus.ev_ready   = aclr_n;
    assign bus.ld_ready   = aclr_n && !bus.ev_valid;

    assign w_fill_grant = bus.fill_valid && bus.fill_ready;
    assign w_st_grant   = bus.st_valid && bus.st_ready;
    assign w_wr_grant   = w_fill_grant || w_st_grant;
    assign w_ev_grant   = bus.ev_valid && bus.ev_ready;
    assign w_ld_grant   = bus.ld_valid && bus.ld_ready;
    assign w_rd_grant   = w_ev_grant || w_ld_grant;

    assign w_wr_addr = w_fill_grant ? bus.fill_addr : bus.st_addr;
    assign w_wr_data = w_fill_grant ? bus.fill_data : bus.st_data;
    assign w_wr_be   = w_fill_grant ? {NUM_BYTES_PER_ENTRY{1'b1}} : bus.st_byteena;

    assign bus.bram_aclr      = !aclr_n;
    assign bus.bram_wren      = w_wr_grant;
    assign bus.bram_wraddress = w_wr_addr;
    assign bus.bram_data      = w_wr_data;
    assign bus.bram_byteena   = w_wr_be;
    assign bus.bram_rden      = w_rd_grant;
    assign bus.bram_rdaddress = w_ev_grant ? bus.ev_addr : bus.ld_addr;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_starve_cnt <= '0;
            r_rd_pending <= 1'b0;
            r_rd_tag     <= 1'b0;
            r_fwd_en     <= 1'b0;
            r_fwd_data   <= '0;
            r_fwd_be     <= '0;
        end else begin
            if (!bus.st_valid || w_st_grant) begin
                r_starve_cnt <= '0;
            end else if (w_fill_grant && (r_starve_cnt != STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
            r_rd_pending <= w_rd_grant;
            r_rd_tag     <= w_ev_grant;
            // The BRAM returns the pre-write line on a same-cycle collision,
            // so a colliding load must patch the written bytes in itself.
            r_fwd_en     <= w_ld_grant && w_wr_grant && (bus.ld_addr == w_wr_addr);
            r_fwd_data   <= w_wr_data;
            r_fwd_be     <= w_wr_be;
        end
    end

    always_comb begin
        w_ld_merged = bus.bram_q;
        for (int b = 0; b < NUM_BYTES_PER_ENTRY; b++) begin
            if (r_fwd_en && r_fwd_be[b]) begin
                w_ld_merged[b*8 +: 8] = r_fwd_data[b*8 +: 8];
            end
        end
    end

    assign bus.ld_rvalid = r_rd_pending && !r_rd_tag;
    assign bus.ev_rvalid = r_rd_pending && r_rd_tag;
    assign bus.ld_rdata  = aclr_n ? w_ld_merged : '0;
    assign bus.ev_rdata  = aclr_n ? bus.bram_q : '0;
endmodule

// File: tb/tb_data_bram_arbiter.sv
// tb/tb_data_bram_arbiter.sv - Self-checking bench for data_bram_arbiter
module tb_data_bram_arbiter;
    localparam int DW   = 256;
    localparam int AW   = 8;
    localparam int NB   = DW / 8;
    localparam int SMAX = 4;

    logic clock;
    logic aclr_n;
    logic mem_clear;

    int n_checks;
    int n_errors;

    data_bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES_PER_ENTRY(NB)) bus ();

    data_bram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES_PER_ENTRY(NB), .STARVE_MAX(SMAX)
    ) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM: registered read, read-before-write on same-address collision.
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << AW); i++) bram_mem[i] <= '0;
            bus.bram_q <= '0;
        end else begin
            if (bus.bram_rden) bus.bram_q <= bram_mem[bus.bram_rdaddress];
            if (bus.bram_wren) begin
                for (int b = 0; b < NB; b++)
                    if (bus.bram_byteena[b])
                        bram_mem[bus.bram_wraddress][b*8 +: 8] <= bus.bram_data[b*8 +: 8];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    int            m_starve;
    logic          exp_ld_rv, exp_ev_rv;
    logic [DW-1:0] exp_data;
    logic          obs_st_grant;
    int            cur_wait, max_wait;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic idle_inputs();
        bus.fill_valid = 0; bus.st_valid = 0; bus.ld_valid = 0; bus.ev_valid = 0;
    endtask

    // One clock cycle: check readies/strobes before the edge against the
    // model, advance the model, then check the read response after the edge.
    task automatic step();
        logic sp, fr, sr, lr, fg, sg, lg, eg;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NB-1:0] wb;
        @(negedge clock);
        sp = bus.st_valid && (m_starve == SMAX);
        fr = !sp;
        sr = !bus.fill_valid || sp;
        lr = !bus.ev_valid;
        chk("fill_ready", DW'(bus.fill_ready), DW'(fr));
        chk("st_ready",   DW'(bus.st_ready),   DW'(sr));
        chk("ev_ready",   DW'(bus.ev_ready),   DW'(1'b1));
        chk("ld_ready",   DW'(bus.ld_ready),   DW'(lr));
        fg = bus.fill_valid && fr;
        sg = bus.st_valid && sr;
        eg = bus.ev_valid;
        lg = bus.ld_valid && lr;
        chk("bram_wren", DW'(bus.bram_wren), DW'(fg || sg));
        chk("bram_rden", DW'(bus.bram_rden), DW'(eg || lg));
        obs_st_grant = bus.st_valid && bus.st_ready;
        if (bus.st_valid && !bus.st_ready) cur_wait++;
        else cur_wait = 0;
        if (cur_wait > max_wait) max_wait = cur_wait;
        if (fg) begin wa = bus.fill_addr; wd = bus.fill_data; wb = '1; end
        else begin wa = bus.st_addr; wd = bus.st_data; wb = bus.st_byteena; end
        exp_ld_rv = lg && !eg;
        exp_ev_rv = eg;
        exp_data  = '0;
        if (eg) exp_data = m_mem[bus.ev_addr];
        else if (lg) begin
            exp_data = m_mem[bus.ld_addr];
            if ((fg || sg) && wa == bus.ld_addr)
                for (int b = 0; b < NB; b++) if (wb[b]) exp_data[b*8 +: 8] = wd[b*8 +: 8];
        end
        if (fg || sg)
            for (int b = 0; b < NB; b++) if (wb[b]) m_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
        if (!bus.st_valid || sg) m_starve = 0;
        else if (fg && m_starve < SMAX) m_starve++;
        @(posedge clock);
        #1;
        chk("ld_rvalid", DW'(bus.ld_rvalid), DW'(exp_ld_rv));
        chk("ev_rvalid", DW'(bus.ev_rvalid), DW'(exp_ev_rv));
        if (exp_ld_rv) chk("ld_rdata", bus.ld_rdata, exp_data);
        if (exp_ev_rv) chk("ev_rdata", bus.ev_rdata, exp_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fill_ready"}, DW'(bus.fill_ready), '0);
        chk({tag, "_st_ready"},   DW'(bus.st_ready),   '0);
        chk({tag, "_ld_ready"},   DW'(bus.ld_ready),   '0);
        chk({tag, "_ev_ready"},   DW'(bus.ev_ready),   '0);
        chk({tag, "_ld_rvalid"},  DW'(bus.ld_rvalid),  '0);
        chk({tag, "_ev_rvalid"},  DW'(bus.ev_rvalid),  '0);
        chk({tag, "_bram_wren"},  DW'(bus.bram_wren),  '0);
        chk({tag, "_bram_rden"},  DW'(bus.bram_rden),  '0);
        chk({tag, "_ld_rdata"},   bus.ld_rdata,        '0);
        chk({tag, "_ev_rdata"},   bus.ev_rdata,        '0);
        chk({tag, "_bram_aclr"},  DW'(bus.bram_aclr),  DW'(1'b1));
    endtask

    task automatic model_reset();
        m_starve = 0; exp_ld_rv = 0; exp_ev_rv = 0; cur_wait = 0;
    endtask

    initial begin
        logic [DW-1:0] line;
        logic [9:0]    grant_seq;
        n_checks = 0; n_errors = 0; max_wait = 0;
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        model_reset();
        mem_clear = 1; aclr_n = 0;
        idle_inputs();
        bus.fill_addr = '0; bus.fill_data = '0;
        bus.st_addr = '0; bus.st_data = '0; bus.st_byteena = '0;
        bus.ld_addr = '0; bus.ev_addr = '0;
        bus.fill_valid = 1; bus.st_valid = 1; bus.ld_valid = 1; bus.ev_valid = 1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        idle_inputs();
        mem_clear = 0;
        @(negedge clock);
        aclr_n = 1;

        // Store 0xAA.. to line 5 on the first edge after release, then load it.
        bus.st_valid = 1; bus.st_addr = 5; bus.st_data = {NB{8'hAA}}; bus.st_byteena = '1;
        step();
        idle_inputs();
        bus.ld_valid = 1; bus.ld_addr = 5;
        step();
        chk("req025_ld_rdata", bus.ld_rdata, {NB{8'hAA}});
        idle_inputs();

        // Evict and fill line 3 together: evict sees the old zero line.
        bus.ev_valid = 1; bus.ev_addr = 3;
        bus.fill_valid = 1; bus.fill_addr = 3; bus.fill_data = '1;
        step();
        chk("req027_ev_rdata", bus.ev_rdata, '0);
        idle_inputs();
        bus.ld_valid = 1; bus.ld_addr = 3;
        step();
        chk("req027_ld_rdata", bus.ld_rdata, '1);
        idle_inputs();

        // Zero line 3 again, then load + partial store to it in one cycle.
        bus.fill_valid = 1; bus.fill_addr = 3; bus.fill_data = '0;
        step();
        idle_inputs();
        line = rand_line();
        line[31:0] = 32'h11223344;
        bus.ld_valid = 1; bus.ld_addr = 3;
        bus.st_valid = 1; bus.st_addr = 3; bus.st_data = line; bus.st_byteena = NB'(32'h0000_000F);
        step();
        chk("req026_ld_rdata", bus.ld_rdata, DW'(32'h11223344));
        idle_inputs();

        // Fill and store both held for 10 cycles.
        grant_seq = '0; max_wait = 0; cur_wait = 0;
        bus.fill_valid = 1; bus.st_valid = 1; bus.st_byteena = '1;
        for (int i = 0; i < 10; i++) begin
            bus.fill_addr = AW'(16 + i); bus.fill_data = rand_line();
            bus.st_addr = AW'(32 + i); bus.st_data = rand_line();
            step();
            grant_seq = {grant_seq[8:0], obs_st_grant};
        end
        chk("req028_grant_seq", DW'(grant_seq), DW'(10'b0000100001));
        chk("req028_max_wait_ok", DW'(max_wait <= SMAX), DW'(1'b1));
        idle_inputs();

        // Load and evict together: evict wins while it stays valid.
        bus.ld_valid = 1; bus.ld_addr = 5;
        bus.ev_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ev_addr = AW'(16 + i);
            step();
        end
        bus.ev_valid = 0;
        step();
        chk("req029_ld_after_ev", bus.ld_rdata, {NB{8'hAA}});

        // Reset mid-stream right after a load was granted.
        bus.fill_valid = 1; bus.fill_addr = 40; bus.fill_data = rand_line();
        bus.st_valid = 1; bus.st_addr = 41; bus.st_data = rand_line();
        bus.ld_valid = 1; bus.ld_addr = 5;
        step();
        aclr_n = 0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        aclr_n = 1;
        #1;
        chk("rel_ld_rvalid", DW'(bus.ld_rvalid), '0);
        chk("rel_ev_rvalid", DW'(bus.ev_rvalid), '0);
        step();
        idle_inputs();

        // Randomized traffic over a few lines so collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            bus.fill_valid = 1'($urandom_range(0, 1));
            bus.fill_addr  = AW'($urandom_range(0, 3));
            bus.fill_data  = rand_line();
            bus.st_valid   = 1'($urandom_range(0, 1));
            bus.st_addr    = AW'($urandom_range(0, 3));
            bus.st_data    = rand_line();
            bus.st_byteena = NB'({$urandom(), $urandom()});
            bus.ld_valid   = 1'($urandom_range(0, 1));
            bus.ld_addr    = AW'($urandom_range(0, 3));
            bus.ev_valid   = ($urandom_range(0, 3) == 0);
            bus.ev_addr    = AW'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
